grostl_shift_bytes_stream: RTL

GROSTL_SHIFT_BYTES_STREAM -- requirements
Module: grostl_shift_bytes_stream

---
 rtl/grostl_shift_bytes_stream.sv | 110 +++++++++++
 1 files changed

// File: rtl/grostl_shift_bytes_stream.sv
// Grostl ShiftBytes on a column stream: a ping-pong pair of state banks is filled
// one 64-bit column per cycle and drained with per-row cyclic column offsets.
module grostl_shift_bytes_stream #(
  parameter int COLS = 8,
  parameter int ROWS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_col,
  input  logic        in_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_col,
  output logic        out_first,
  output logic        out_last,
  output logic        out_mode
);

  localparam int CW = $clog2(COLS);

  if (!(COLS == 8 || COLS == 16)) begin : g_bad_cols
    $error("grostl_shift_bytes_stream: COLS must be 8 or 16");
  end

  logic [63:0]   r_bank [2][COLS];
  logic [1:0]    r_full;
  logic [1:0]    r_mode;
  logic          r_wr_bank;
  logic          r_rd_bank;
  logic [CW-1:0] r_wr_cnt;
  logic [CW-1:0] r_rd_cnt;

  logic          w_in_fire;
  logic          w_out_fire;
  logic [63:0]   w_out_col;

  // Row shift: P uses the row index, Q the odd/even interleave; the wide state
  // moves one row (P row 7, Q row 3) out to offset 11.
  function automatic logic [3:0] shift_of(input logic q, input int row);
    logic [3:0] s;
    s = 4'(row);
    if (q) s = (row < 4) ? 4'(2 * row + 1) : 4'(2 * (row - 4));
    if (COLS == 16 && q && row == 3) s = 4'd11;
    if (COLS == 16 && !q && row == 7) s = 4'd11;
    return s;
  endfunction

  assign in_ready   = !reset && !r_full[r_wr_bank];
  assign out_valid  = r_full[r_rd_bank];
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;

  // NOTE: bank storage carries no reset; the full flags alone decide whether
  // its contents are meaningful, so stale data is never observable.
  always_ff @(posedge clk) begin
    if (w_in_fire) r_bank[r_wr_bank][r_wr_cnt] <= in_col;
  end

  // NOTE: all state updates are non-blocking so every read in this block sees
  // the pre-edge value, which lets fill and drain touch different banks safely.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_full    <= '0;
      r_mode    <= '0;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_wr_cnt  <= '0;
      r_rd_cnt  <= '0;
    end else begin
      if (w_in_fire) begin
        if (r_wr_cnt == '0) r_mode[r_wr_bank] <= in_mode;
        if (r_wr_cnt == CW'(COLS - 1)) begin
          r_full[r_wr_bank] <= 1'b1;
          r_wr_cnt          <= '0;
          r_wr_bank         <= ~r_wr_bank;
        end else begin
          r_wr_cnt <= r_wr_cnt + 1'b1;
        end
      end
      if (w_out_fire) begin
        if (r_rd_cnt == CW'(COLS - 1)) begin
          r_full[r_rd_bank] <= 1'b0;
          r_rd_cnt          <= '0;
          r_rd_bank         <= ~r_rd_bank;
        end else begin
          r_rd_cnt <= r_rd_cnt + 1'b1;
        end
      end
    end
  end

  // Column index wraps naturally because COLS is a power of two.
  always_comb begin
    w_out_col = '0;
    if (out_valid) begin
      for (int r = 0; r < ROWS; r++) begin
        w_out_col[63 - 8 * r -: 8] =
          r_bank[r_rd_bank][r_rd_cnt + CW'(shift_of(r_mode[r_rd_bank], r))][63 - 8 * r -: 8];
      end
    end
  end

  assign out_col   = w_out_col;
  assign out_first = out_valid && (r_rd_cnt == '0);
  assign out_last  = out_valid && (r_rd_cnt == CW'(COLS - 1));
  assign out_mode  = out_valid && r_mode[r_rd_bank];

endmodule
